// File: rtl/race_lap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : race_lap_timer
//  Description : Multi-lap race timer for the pclk domain. Runs a pre-race
//                countdown, times each lap and the whole race in ticks,
//                filters implausibly short laps, tracks the best lap and
//                flags when the configured number of laps is complete.
//  Revision    : 1.0  initial release
// ============================================================================
module race_lap_timer #(
  parameter int CLK_HZ        = 65_000_000,
  parameter int TICK_HZ       = 100,
  parameter int LAPS          = 3,
  parameter int TIME_W        = 16,
  parameter int COUNTDOWN_S   = 3,
  parameter int MIN_LAP_TICKS = 200
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              start,
  input  logic              lap_finished,
  output logic [TIME_W-1:0] current_lap_time,
  output logic [TIME_W-1:0] last_lap_time,
  output logic [TIME_W-1:0] best_lap_time,
  output logic [TIME_W-1:0] total_time,
  output logic [7:0]        lap_count,
  output logic [3:0]        countdown,
  output logic              racing,
  output logic              race_done,
  output logic              new_best
);

  // Clock cycles per tick, and ticks per countdown second.
  localparam int c_div   = CLK_HZ / TICK_HZ;
  localparam int c_div_w = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int c_sub_w = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;

  localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(c_div - 1);
  localparam logic [c_sub_w-1:0] c_sub_last  = c_sub_w'(TICK_HZ - 1);
  localparam logic [TIME_W:0]    c_min_lap   = (TIME_W + 1)'(MIN_LAP_TICKS);
  localparam logic [7:0]         c_laps      = 8'(LAPS);
  localparam logic [3:0]         c_countdown = 4'(COUNTDOWN_S);
  localparam logic [TIME_W-1:0]  c_time_max  = {TIME_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RACING    = 2'd2,
    S_FINISHED  = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic [c_div_w-1:0]  divider_q,   divider_d;
  logic [c_sub_w-1:0]  sub_q,       sub_d;
  logic [3:0]          countdown_q, countdown_d;
  logic [TIME_W-1:0]   current_q,   current_d;
  logic [TIME_W-1:0]   last_q,      last_d;
  logic [TIME_W-1:0]   best_q,      best_d;
  logic [TIME_W-1:0]   total_q,     total_d;
  logic [7:0]          lap_count_q, lap_count_d;
  logic                new_best_q,  new_best_d;

  logic w_tick;
  logic w_lap_ok;

  assign w_tick   = (divider_q == c_div_last);
  // Laps shorter than the minimum are treated as checkpoint glitches.
  assign w_lap_ok = lap_finished && ({1'b0, current_q} >= c_min_lap);

  // Next-state and next-output logic for the race sequencer.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    countdown_d = countdown_q;
    current_d   = current_q;
    last_d      = last_q;
    best_d      = best_q;
    total_d     = total_q;
    lap_count_d = lap_count_q;
    new_best_d  = 1'b0;
    divider_d   = divider_q;

    case (state_q)
      S_IDLE: begin
        sub_d       = '0;
        countdown_d = 4'd0;
        current_d   = '0;
        last_d      = '0;
        total_d     = '0;
        lap_count_d = 8'd0;
        if (start) begin
          state_d     = S_COUNTDOWN;
          countdown_d = c_countdown;
        end
      end

      S_COUNTDOWN: begin
        if (!start) begin
          state_d = S_IDLE;
        end else if (w_tick) begin
          if (sub_q == c_sub_last) begin
            sub_d = '0;
            if (countdown_q <= 4'd1) begin
              state_d     = S_RACING;
              countdown_d = 4'd0;
              current_d   = '0;
              total_d     = '0;
            end else begin
              countdown_d = countdown_q - 4'd1;
            end
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end

      S_RACING: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          // Both timers saturate rather than wrap.
          if (w_tick) begin
            if (total_q != c_time_max) total_d = total_q + 1'b1;
            if (current_q != c_time_max) current_d = current_q + 1'b1;
          end
          // An accepted lap overrides any coincident tick on the lap timer.
          if (w_lap_ok) begin
            last_d      = current_q;
            current_d   = '0;
            lap_count_d = lap_count_q + 8'd1;
            if (current_q < best_q) begin
              best_d     = current_q;
              new_best_d = 1'b1;
            end
            if ((lap_count_q + 8'd1) == c_laps) begin
              state_d = S_FINISHED;
            end
          end
        end
      end

      S_FINISHED: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort clears the race immediately; only the best lap survives.
    if (state_q != S_IDLE && !start) begin
      sub_d       = '0;
      countdown_d = 4'd0;
      current_d   = '0;
      last_d      = '0;
      total_d     = '0;
      lap_count_d = 8'd0;
      new_best_d  = 1'b0;
    end

    // Tick divider restarts on every state change so the first tick in a
    // state lands a full period after entry.
    if (state_d != state_q) begin
      divider_d = '0;
      sub_d     = '0;
    end else if (state_q == S_IDLE) begin
      divider_d = '0;
    end else if (w_tick) begin
      divider_d = '0;
    end else begin
      divider_d = divider_q + 1'b1;
    end
  end

  // Register all state and outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      divider_q   <= '0;
      sub_q       <= '0;
      countdown_q <= 4'd0;
      current_q   <= '0;
      last_q      <= '0;
      best_q      <= c_time_max;
      total_q     <= '0;
      lap_count_q <= 8'd0;
      new_best_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      divider_q   <= divider_d;
      sub_q       <= sub_d;
      countdown_q <= countdown_d;
      current_q   <= current_d;
      last_q      <= last_d;
      best_q      <= best_d;
      total_q     <= total_d;
      lap_count_q <= lap_count_d;
      new_best_q  <= new_best_d;
    end
  end

  assign current_lap_time = current_q;
  assign last_lap_time    = last_q;
  assign best_lap_time    = best_q;
  assign total_time       = total_q;
  assign lap_count        = lap_count_q;
  assign countdown        = countdown_q;
  assign new_best         = new_best_q;
  assign racing           = (state_q == S_RACING);
  assign race_done        = (state_q == S_FINISHED);

endmodule
`default_nettype wire

// File: tb/tb_race_lap_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_race_lap_timer
//  Description : Directed self-checking bench for race_lap_timer using a
//                small configuration (DIV=10, 2 laps, 2 s countdown).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_race_lap_timer;

  logic       pclk;
  logic       rst;
  logic       start;
  logic       lap_finished;
  logic [7:0] current_lap_time;
  logic [7:0] last_lap_time;
  logic [7:0] best_lap_time;
  logic [7:0] total_time;
  logic [7:0] lap_count;
  logic [3:0] countdown;
  logic       racing;
  logic       race_done;
  logic       new_best;

  int errors;
  int checks;
  logic nb_seen;

  race_lap_timer #(
    .CLK_HZ       (100),
    .TICK_HZ      (10),
    .LAPS         (2),
    .TIME_W       (8),
    .COUNTDOWN_S  (2),
    .MIN_LAP_TICKS(3)
  ) dut (
    .pclk            (pclk),
    .rst             (rst),
    .start           (start),
    .lap_finished    (lap_finished),
    .current_lap_time(current_lap_time),
    .last_lap_time   (last_lap_time),
    .best_lap_time   (best_lap_time),
    .total_time      (total_time),
    .lap_count       (lap_count),
    .countdown       (countdown),
    .racing          (racing),
    .race_done       (race_done),
    .new_best        (new_best)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge pclk);
      #1;
      if (new_best === 1'b1) nb_seen = 1'b1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    nb_seen      = 1'b0;
    rst          = 1'b1;
    start        = 1'b0;
    lap_finished = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    check("rst_current", 32'(current_lap_time), 0);
    check("rst_last", 32'(last_lap_time), 0);
    check("rst_best", 32'(best_lap_time), 255);
    check("rst_total", 32'(total_time), 0);
    check("rst_laps", 32'(lap_count), 0);
    check("rst_countdown", 32'(countdown), 0);
    check("rst_racing", 32'(racing), 0);
    check("rst_done", 32'(race_done), 0);
    check("rst_new_best", 32'(new_best), 0);

    // Countdown: entry edge is edge 0
    start = 1'b1;
    step(1);
    check("cd_start", 32'(countdown), 2);
    check("cd_not_racing", 32'(racing), 0);
    step(99);
    check("cd_edge99", 32'(countdown), 2);
    step(1);
    check("cd_edge100", 32'(countdown), 1);
    step(99);
    check("cd_edge199_racing", 32'(racing), 0);
    step(1);
    check("race_entry_racing", 32'(racing), 1);
    check("race_entry_countdown", 32'(countdown), 0);
    check("race_entry_current", 32'(current_lap_time), 0);
    step(10);
    check("first_tick_current", 32'(current_lap_time), 1);
    check("first_tick_total", 32'(total_time), 1);

    // Lap capture at current=7
    step(60);
    check("pre_lap1_current", 32'(current_lap_time), 7);
    lap_finished = 1'b1;
    step(1);
    lap_finished = 1'b0;
    check("lap1_last", 32'(last_lap_time), 7);
    check("lap1_best", 32'(best_lap_time), 7);
    check("lap1_new_best", 32'(new_best), 1);
    check("lap1_count", 32'(lap_count), 1);
    check("lap1_current", 32'(current_lap_time), 0);
    check("lap1_total", 32'(total_time), 7);
    step(1);
    check("lap1_new_best_drop", 32'(new_best), 0);

    // Short lap filtered at current=2
    step(18);
    check("pre_short_current", 32'(current_lap_time), 2);
    lap_finished = 1'b1;
    step(1);
    lap_finished = 1'b0;
    check("short_count", 32'(lap_count), 1);
    check("short_current", 32'(current_lap_time), 2);
    check("short_last", 32'(last_lap_time), 7);

    // Final lap at current=5 finishes the race
    step(29);
    check("pre_lap2_current", 32'(current_lap_time), 5);
    check("pre_lap2_total", 32'(total_time), 12);
    lap_finished = 1'b1;
    step(1);
    lap_finished = 1'b0;
    check("lap2_last", 32'(last_lap_time), 5);
    check("lap2_best", 32'(best_lap_time), 5);
    check("lap2_new_best", 32'(new_best), 1);
    check("lap2_count", 32'(lap_count), 2);
    check("lap2_done", 32'(race_done), 1);
    check("lap2_racing", 32'(racing), 0);
    step(30);
    check("frozen_total", 32'(total_time), 12);
    check("frozen_current", 32'(current_lap_time), 0);
    check("frozen_done", 32'(race_done), 1);

    // Leave FINISHED, second race: tie then worse lap
    start = 1'b0;
    step(1);
    check("idle_done", 32'(race_done), 0);
    check("idle_count", 32'(lap_count), 0);
    check("idle_last", 32'(last_lap_time), 0);
    check("idle_best_kept", 32'(best_lap_time), 5);
    start   = 1'b1;
    nb_seen = 1'b0;
    step(1);
    check("r2_countdown", 32'(countdown), 2);
    step(200);
    check("r2_racing", 32'(racing), 1);
    step(50);
    check("r2_pre_tie", 32'(current_lap_time), 5);
    lap_finished = 1'b1;
    step(1);
    lap_finished = 1'b0;
    check("tie_last", 32'(last_lap_time), 5);
    check("tie_best", 32'(best_lap_time), 5);
    check("tie_count", 32'(lap_count), 1);
    step(89);
    check("r2_pre_worse", 32'(current_lap_time), 9);
    lap_finished = 1'b1;
    step(1);
    lap_finished = 1'b0;
    check("worse_last", 32'(last_lap_time), 9);
    check("worse_best", 32'(best_lap_time), 5);
    check("worse_done", 32'(race_done), 1);
    check("r2_no_new_best", 32'(nb_seen), 0);

    // Third race: saturation after 300 ticks without a lap
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    step(200);
    check("r3_racing", 32'(racing), 1);
    step(3000);
    check("sat_current", 32'(current_lap_time), 255);
    check("sat_total", 32'(total_time), 255);

    // Abort coincident with a valid lap
    start        = 1'b0;
    lap_finished = 1'b1;
    step(1);
    lap_finished = 1'b0;
    check("abort_racing", 32'(racing), 0);
    check("abort_count", 32'(lap_count), 0);
    check("abort_current", 32'(current_lap_time), 0);
    check("abort_total", 32'(total_time), 0);
    check("abort_last", 32'(last_lap_time), 0);
    check("abort_best", 32'(best_lap_time), 5);
    check("abort_new_best", 32'(new_best), 0);

    // Reset clears best
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst2_best", 32'(best_lap_time), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
